// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
// Frame layout: 2 length bytes (LE word count), 4*N data bytes, 1 XOR checksum byte.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } loader_state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  localparam int FRAME_HDR_BYTES = 2;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a byte stream into 32-bit little-endian words; word_valid pulses the
// cycle after the fourth byte of a word is accepted, while word holds it.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        data_en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        last_byte
);

  logic [31:0] shift_r;
  logic [1:0]  idx_r;
  logic        valid_r;

  // Bytes enter at the top, so after four shifts the first byte sits in [7:0]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= 32'd0;
      idx_r   <= 2'd0;
      valid_r <= 1'b0;
    end else if (clr) begin
      shift_r <= 32'd0;
      idx_r   <= 2'd0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= data_en && (idx_r == 2'd3);
      if (data_en) begin
        shift_r <= {data, shift_r[31:8]};
        idx_r   <= idx_r + 2'd1;
      end
    end
  end

  assign word       = shift_r;
  assign word_valid = valid_r;
  assign last_byte  = (idx_r == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: receives a framed image, writes it word by word
// into instruction memory from address 0, and releases core_hold on a clean load.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  // Word count is 17 bits so that a full 2**ADDR_WIDTH image is representable
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  loader_state_t         state_r, state_nxt_s;
  logic                  busy_s, xfer_s, start_ok_s, asm_en_s, word_acc_s;
  logic                  word_valid_s, last_byte_s, last_word_s, len_ok_s;
  logic [7:0]            len_lo_r, csum_r;
  logic [16:0]           len_s, nwords_r, wcount_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH:0]   wl_r;
  logic [1:0]            err_r;
  logic [31:0]           word_s;

  assign busy_s      = (state_r == ST_LEN_LO) || (state_r == ST_LEN_HI) ||
                       (state_r == ST_DATA)   || (state_r == ST_CHECK);
  assign xfer_s      = in_valid && busy_s;
  assign start_ok_s  = start && !busy_s;
  assign asm_en_s    = xfer_s && (state_r == ST_DATA);
  assign word_acc_s  = asm_en_s && last_byte_s;
  assign len_s       = {1'b0, in_data, len_lo_r};
  assign len_ok_s    = (len_s >= 17'd1) && (len_s <= MAX_WORDS);
  assign last_word_s = (wcount_r == (nwords_r - 17'd1));

  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (reset),
    .clr        (start_ok_s),
    .data_en    (asm_en_s),
    .data       (in_data),
    .word       (word_s),
    .word_valid (word_valid_s),
    .last_byte  (last_byte_s)
  );

  // Frame sequencing; start is honoured only outside the receiving states
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_nxt_s = ST_LEN_LO;
        else       state_nxt_s = state_r;
      end
      ST_LEN_LO: begin
        if (xfer_s) state_nxt_s = ST_LEN_HI;
        else        state_nxt_s = state_r;
      end
      ST_LEN_HI: begin
        if (xfer_s) state_nxt_s = len_ok_s ? ST_DATA : ST_ERROR;
        else        state_nxt_s = state_r;
      end
      ST_DATA: begin
        if (word_acc_s && last_word_s) state_nxt_s = ST_CHECK;
        else                           state_nxt_s = state_r;
      end
      ST_CHECK: begin
        if (xfer_s) state_nxt_s = (in_data == csum_r) ? ST_DONE : ST_ERROR;
        else        state_nxt_s = state_r;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Length capture, checksum, word/address counters and error code
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo_r <= 8'd0;
      nwords_r <= 17'd0;
      wcount_r <= 17'd0;
      csum_r   <= 8'd0;
      addr_r   <= {ADDR_WIDTH{1'b0}};
      wl_r     <= {(ADDR_WIDTH+1){1'b0}};
      err_r    <= ERR_NONE;
    end else if (start_ok_s) begin
      len_lo_r <= 8'd0;
      nwords_r <= 17'd0;
      wcount_r <= 17'd0;
      csum_r   <= 8'd0;
      addr_r   <= {ADDR_WIDTH{1'b0}};
      wl_r     <= {(ADDR_WIDTH+1){1'b0}};
      err_r    <= ERR_NONE;
    end else begin
      if (xfer_s && (state_r == ST_LEN_LO)) len_lo_r <= in_data;
      if (xfer_s && (state_r == ST_LEN_HI)) begin
        nwords_r <= len_s;
        if (!len_ok_s) err_r <= ERR_LEN;
      end
      if (asm_en_s)   csum_r   <= csum_update(csum_r, in_data);
      if (word_acc_s) wcount_r <= wcount_r + 17'd1;
      // Address saturates on the last slot so it never wraps back to 0
      if (word_valid_s) begin
        wl_r <= wl_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
        if (addr_r != {ADDR_WIDTH{1'b1}}) addr_r <= addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
      if (xfer_s && (state_r == ST_CHECK) && (in_data != csum_r)) err_r <= ERR_CSUM;
    end
  end

  assign in_ready     = busy_s;
  assign busy         = busy_s;
  assign mem_wr_en    = word_valid_s;
  assign mem_addr     = addr_r;
  assign mem_wdata    = word_s;
  assign core_hold    = (state_r != ST_DONE);
  assign done         = (state_r == ST_DONE);
  assign error        = (state_r == ST_ERROR);
  assign err_code     = err_r;
  assign words_loaded = wl_r;

endmodule
